// File: rtl/sliding_window_gen_pkg.sv
// Shared defaults, pixel type and window-generator state encoding.
package sliding_window_gen_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_KSIZE      = 5;
  localparam int DEF_IMG_WIDTH  = 1920;
  localparam int DEF_IMG_HEIGHT = 1080;

  localparam int COL_W = $clog2(DEF_IMG_WIDTH);
  localparam int ROW_W = $clog2(DEF_IMG_HEIGHT);

  typedef logic [DEF_DATA_WIDTH-1:0] pix_t;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } win_state_e;

  // Number of fully-inside windows produced for one frame.
  function automatic int unsigned win_count(input int unsigned w, input int unsigned h,
                                            input int unsigned k);
    return (w - k + 1) * (h - k + 1);
  endfunction

endpackage

// File: rtl/sliding_window_gen_if.sv
// Column input stream and window output stream of the sliding-window generator.
interface sliding_window_gen_if
  import sliding_window_gen_pkg::*;
#(
  parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
  parameter int IMG_HEIGHT = DEF_IMG_HEIGHT,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int KSIZE      = DEF_KSIZE
);

  logic [KSIZE*DATA_WIDTH-1:0]       col_in;
  logic                              col_valid;
  logic                              line_end;
  logic [KSIZE*KSIZE*DATA_WIDTH-1:0] win_out;
  logic                              win_valid;
  logic [$clog2(IMG_HEIGHT)-1:0]     win_row;
  logic [$clog2(IMG_WIDTH)-1:0]      win_col;
  logic                              frame_done;
  logic                              line_err;

  modport master (
    output col_in, col_valid, line_end,
    input  win_out, win_valid, win_row, win_col, frame_done, line_err
  );

  modport slave (
    input  col_in, col_valid, line_end,
    output win_out, win_valid, win_row, win_col, frame_done, line_err
  );

endinterface

// File: rtl/sliding_window_gen_win_coord_ctrl.sv
// Column/row counters, FILL/RUN sequencing and registered window qualifiers
// (valid, centre coordinates, frame_done, sticky line_err).
module sliding_window_gen_win_coord_ctrl
  import sliding_window_gen_pkg::*;
#(
  parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
  parameter int IMG_HEIGHT = DEF_IMG_HEIGHT,
  parameter int KSIZE      = DEF_KSIZE
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          col_valid,
  input  logic                          line_end,
  output logic                          win_valid,
  output logic [$clog2(IMG_HEIGHT)-1:0] win_row,
  output logic [$clog2(IMG_WIDTH)-1:0]  win_col,
  output logic                          frame_done,
  output logic                          line_err
);

  localparam int COL_BITS = $clog2(IMG_WIDTH);
  localparam int ROW_BITS = $clog2(IMG_HEIGHT);

  localparam logic [COL_BITS-1:0] COL_LAST      = COL_BITS'(IMG_WIDTH - 1);
  localparam logic [COL_BITS-1:0] COL_FIRST_WIN = COL_BITS'(KSIZE - 1);
  localparam logic [COL_BITS-1:0] COL_HALF      = COL_BITS'(KSIZE / 2);
  localparam logic [ROW_BITS-1:0] ROW_LAST      = ROW_BITS'(IMG_HEIGHT - 1);
  localparam logic [ROW_BITS-1:0] ROW_PRE_RUN   = ROW_BITS'(KSIZE - 2);
  localparam logic [ROW_BITS-1:0] ROW_HALF      = ROW_BITS'(KSIZE / 2);

  win_state_e          state_reg, state_next;
  logic [COL_BITS-1:0] col_cnt_reg, col_cnt_next;
  logic [ROW_BITS-1:0] row_cnt_reg, row_cnt_next;
  logic                win_valid_reg, win_valid_next;
  logic [ROW_BITS-1:0] win_row_reg, win_row_next;
  logic [COL_BITS-1:0] win_col_reg, win_col_next;
  logic                frame_done_reg, frame_done_next;
  logic                line_err_reg, line_err_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= FILL;
      col_cnt_reg    <= '0;
      row_cnt_reg    <= '0;
      win_valid_reg  <= 1'b0;
      win_row_reg    <= '0;
      win_col_reg    <= '0;
      frame_done_reg <= 1'b0;
      line_err_reg   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      col_cnt_reg    <= col_cnt_next;
      row_cnt_reg    <= row_cnt_next;
      win_valid_reg  <= win_valid_next;
      win_row_reg    <= win_row_next;
      win_col_reg    <= win_col_next;
      frame_done_reg <= frame_done_next;
      line_err_reg   <= line_err_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    col_cnt_next    = col_cnt_reg;
    row_cnt_next    = row_cnt_reg;
    win_valid_next  = 1'b0;
    win_row_next    = win_row_reg;
    win_col_next    = win_col_reg;
    frame_done_next = 1'b0;
    line_err_next   = line_err_reg;

    if (col_valid) begin
      // Coordinates and qualification use the counters before this beat advances them.
      win_valid_next = (state_reg == RUN) && (col_cnt_reg >= COL_FIRST_WIN);
      win_row_next   = row_cnt_reg - ROW_HALF;
      win_col_next   = col_cnt_reg - COL_HALF;

      if (line_end) begin
        col_cnt_next = '0;
        if (col_cnt_reg != COL_LAST) begin
          line_err_next = 1'b1;
        end
        case (state_reg)
          FILL: begin
            row_cnt_next = row_cnt_reg + ROW_BITS'(1);
            if (row_cnt_reg == ROW_PRE_RUN) begin
              state_next = RUN;
            end
          end
          RUN: begin
            if (row_cnt_reg == ROW_LAST) begin
              row_cnt_next    = '0;
              state_next      = FILL;
              frame_done_next = 1'b1;
            end else begin
              row_cnt_next = row_cnt_reg + ROW_BITS'(1);
            end
          end
          default: state_next = FILL;
        endcase
      end else if (col_cnt_reg == COL_LAST) begin
        // Overlong line: hold the last index until line_end arrives.
        line_err_next = 1'b1;
      end else begin
        col_cnt_next = col_cnt_reg + COL_BITS'(1);
      end
    end
  end

  assign win_valid  = win_valid_reg;
  assign win_row    = win_row_reg;
  assign win_col    = win_col_reg;
  assign frame_done = frame_done_reg;
  assign line_err   = line_err_reg;

endmodule

// File: rtl/sliding_window_gen.sv
// KSIZE x KSIZE pixel window built from streamed vertical columns; the newest
// column enters at c=KSIZE-1 and older columns shift toward c=0.
module sliding_window_gen
  import sliding_window_gen_pkg::*;
#(
  parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
  parameter int IMG_HEIGHT = DEF_IMG_HEIGHT,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int KSIZE      = DEF_KSIZE
) (
  input logic                clk,
  input logic                rst_n,
  sliding_window_gen_if.slave bus
);

  logic [DATA_WIDTH-1:0] col_lane [KSIZE];
  logic [DATA_WIDTH-1:0] win_reg  [KSIZE][KSIZE];

  genvar gi, gj;

  generate
    for (gi = 0; gi < KSIZE; gi++) begin : g_lane
      assign col_lane[gi] = bus.col_in[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  // The window registers double as the output register: they update on the
  // same edge as the registered valid/coordinates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < KSIZE; r++) begin
        for (int c = 0; c < KSIZE; c++) begin
          win_reg[r][c] <= '0;
        end
      end
    end else if (bus.col_valid) begin
      for (int r = 0; r < KSIZE; r++) begin
        for (int c = 0; c < KSIZE - 1; c++) begin
          win_reg[r][c] <= win_reg[r][c+1];
        end
        win_reg[r][KSIZE-1] <= col_lane[r];
      end
    end
  end

  generate
    for (gi = 0; gi < KSIZE; gi++) begin : g_row
      for (gj = 0; gj < KSIZE; gj++) begin : g_col
        assign bus.win_out[(gi*KSIZE+gj)*DATA_WIDTH +: DATA_WIDTH] = win_reg[gi][gj];
      end
    end
  endgenerate

  sliding_window_gen_win_coord_ctrl #(
    .IMG_WIDTH  (IMG_WIDTH),
    .IMG_HEIGHT (IMG_HEIGHT),
    .KSIZE      (KSIZE)
  ) u_ctrl (
    .clk        (clk),
    .rst_n      (rst_n),
    .col_valid  (bus.col_valid),
    .line_end   (bus.line_end),
    .win_valid  (bus.win_valid),
    .win_row    (bus.win_row),
    .win_col    (bus.win_col),
    .frame_done (bus.frame_done),
    .line_err   (bus.line_err)
  );

endmodule

// File: tb/tb_sliding_window_gen.sv
// Directed bench for sliding_window_gen on an 8x6 frame with a 5x5 window;
// expected windows are queued per beat and matched as the DUT emits them.
module tb_sliding_window_gen;
  import sliding_window_gen_pkg::*;

  localparam int W    = 8;
  localparam int H    = 6;
  localparam int K    = 5;
  localparam int DW   = 8;
  localparam int WB   = K * K * DW;
  localparam int HALF = K / 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sliding_window_gen_if #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .DATA_WIDTH(DW), .KSIZE(K)) sw_if ();

  sliding_window_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .DATA_WIDTH(DW), .KSIZE(K)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sw_if)
  );

  typedef struct {
    int          row;
    int          col;
    logic [WB-1:0] win;
    logic        fd;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   win_cnt = 0;
  int   fd_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [WB-1:0] obs, input logic [WB-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Pixel of the synthetic image; rows above the frame read as zero.
  function automatic pix_t pix(input int y, input int x);
    if (y < 0) return '0;
    return pix_t'(y * 16 + x);
  endfunction

  function automatic logic [WB-1:0] exp_win(input int y, input int xs);
    logic [WB-1:0] w;
    w = '0;
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++)
        w[(r*K+c)*DW +: DW] = pix(y - (K-1) + r, xs - (K-1) + c);
    return w;
  endfunction

  // Scoreboard: every emitted window is matched against the oldest queued one.
  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].due < cyc) begin
      e = sb.pop_front();
      check("win_missing", WB'(e.due), WB'(cyc));
    end
    if (sw_if.win_valid) begin
      win_cnt++;
      if (sw_if.frame_done) fd_cnt++;
      if (sb.size() == 0) begin
        check("win_unexpected", WB'(sw_if.win_valid), WB'(0));
      end else begin
        e = sb.pop_front();
        check("win_latency", WB'(cyc), WB'(e.due));
        check("win_row", WB'(sw_if.win_row), WB'(e.row));
        check("win_col", WB'(sw_if.win_col), WB'(e.col));
        check("win_out", sw_if.win_out, e.win);
        check("frame_done", WB'(sw_if.frame_done), WB'(e.fd));
      end
    end else if (sw_if.frame_done) begin
      fd_cnt++;
      check("frame_done_alone", WB'(sw_if.win_valid), WB'(1));
    end
  end

  task automatic beat(input int y, input int xs, input logic le, input int gap);
    exp_t e;
    int   xc;
    for (int i = 0; i < K; i++) sw_if.col_in[i*DW +: DW] = pix(y - (K-1) + i, xs);
    sw_if.col_valid = 1'b1;
    sw_if.line_end  = le;
    xc = (xs > W - 1) ? W - 1 : xs;
    if (y >= K - 1 && xs >= K - 1) begin
      e.row = y - HALF;
      e.col = xc - HALF;
      e.win = exp_win(y, xs);
      e.fd  = le && (y == H - 1);
      e.due = cyc + 1;
      sb.push_back(e);
    end
    @(negedge clk);
    sw_if.col_valid = 1'b0;
    sw_if.line_end  = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic line(input int y, input int n, input logic le, input int gap);
    for (int x = 0; x < n; x++) beat(y, x, le && (x == n - 1), gap);
  endtask

  task automatic frame(input int gap);
    for (int y = 0; y < H; y++) line(y, W, 1'b1, gap);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_win_out"}, sw_if.win_out, '0);
    check({tag, "_win_valid"}, WB'(sw_if.win_valid), '0);
    check({tag, "_win_row"}, WB'(sw_if.win_row), '0);
    check({tag, "_win_col"}, WB'(sw_if.win_col), '0);
    check({tag, "_frame_done"}, WB'(sw_if.frame_done), '0);
    check({tag, "_line_err"}, WB'(sw_if.line_err), '0);
  endtask

  task automatic check_counts(input string tag, input int w0, input int f0,
                              input int nw, input int nf);
    check({tag, "_windows"}, WB'(win_cnt - w0), WB'(nw));
    check({tag, "_frame_done_cnt"}, WB'(fd_cnt - f0), WB'(nf));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, f0;
    sw_if.col_in    = '0;
    sw_if.col_valid = 1'b0;
    sw_if.line_end  = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_idle("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Test 1: single full frame, continuous beats
    w0 = win_cnt; f0 = fd_cnt;
    frame(0);
    repeat (3) @(negedge clk);
    check_counts("t1", w0, f0, win_count(W, H, K), 1);

    // Test 6: two back-to-back frames
    w0 = win_cnt; f0 = fd_cnt;
    frame(0);
    frame(0);
    repeat (3) @(negedge clk);
    check_counts("t6", w0, f0, 2 * win_count(W, H, K), 2);

    // Test 2: gapped input, one beat in three
    w0 = win_cnt; f0 = fd_cnt;
    frame(2);
    repeat (3) @(negedge clk);
    check_counts("t2", w0, f0, win_count(W, H, K), 1);
    check("t2_line_err", WB'(sw_if.line_err), '0);

    // Test 3: line 4 ends after 6 columns
    w0 = win_cnt; f0 = fd_cnt;
    for (int y = 0; y < 4; y++) line(y, W, 1'b1, 0);
    line(4, 6, 1'b1, 0);
    check("t3_line_err_set", WB'(sw_if.line_err), WB'(1));
    line(5, W, 1'b1, 0);
    repeat (5) @(negedge clk);
    check("t3_line_err_sticky", WB'(sw_if.line_err), WB'(1));
    check_counts("t3", w0, f0, 2 + 4, 1);

    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_idle("t3_reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Test 4: line 4 runs 3 beats past the width before line_end
    w0 = win_cnt; f0 = fd_cnt;
    for (int y = 0; y < 4; y++) line(y, W, 1'b1, 0);
    line(4, W + 3, 1'b1, 0);
    check("t4_line_err", WB'(sw_if.line_err), WB'(1));
    line(5, W, 1'b1, 0);
    repeat (3) @(negedge clk);
    check_counts("t4", w0, f0, 7 + 4, 1);

    // Test 5: reset mid-frame at row 3 col 4, then a clean frame
    for (int y = 0; y < 3; y++) line(y, W, 1'b1, 0);
    line(3, 5, 1'b0, 0);
    rst_n = 1'b0;
    @(negedge clk);
    check_idle("t5_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    w0 = win_cnt; f0 = fd_cnt;
    frame(0);
    repeat (3) @(negedge clk);
    check_counts("t5", w0, f0, win_count(W, H, K), 1);
    check("t5_line_err", WB'(sw_if.line_err), '0);

    check("scoreboard_drained", WB'(sb.size()), '0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
